// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: widths, optype encodings and constants.
package alu_exec_unit_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OP_W   = 6;

    localparam logic [TAG_W-1:0]  RENAMED_ZERO = '0;
    localparam logic [DATA_W-1:0] ZERO         = '0;
    localparam logic              TRUE         = 1'b1;
    localparam logic              FALSE        = 1'b0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_SLL   = 6'd3,
        OP_SLT   = 6'd4,
        OP_SLTU  = 6'd5,
        OP_XOR   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_OR    = 6'd9,
        OP_AND   = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21,
        OP_JAL   = 6'd22,
        OP_JALR  = 6'd23,
        OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25,
        OP_BLT   = 6'd26,
        OP_BGE   = 6'd27,
        OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } optype_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational RV32I datapath: result, branch/jump flags and next-pc target for one optype.
module alu_compute
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = alu_exec_unit_pkg::DATA_W,
    parameter int OP_W   = alu_exec_unit_pkg::OP_W
) (
    input  logic [OP_W-1:0]   i_optype,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_vi,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_is_jump,
    output logic              o_taken,
    output logic [DATA_W-1:0] o_target,
    output logic              o_legal
);

    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_pc_imm;
    logic              w_is_branch;
    logic              w_cond;

    assign w_pc4    = i_pc + DATA_W'(4);
    assign w_pc_imm = i_pc + i_imm;

    always_comb begin
        o_result    = ZERO[DATA_W-1:0];
        o_is_jump   = FALSE;
        o_taken     = FALSE;
        o_target    = w_pc4;
        o_legal     = TRUE;
        w_is_branch = FALSE;
        w_cond      = FALSE;
        case (i_optype)
            OP_NOP:   o_result = ZERO[DATA_W-1:0];
            OP_ADD:   o_result = i_vi + i_vj;
            OP_SUB:   o_result = i_vi - i_vj;
            OP_SLL:   o_result = i_vi << i_vj[4:0];
            OP_SLT:   o_result = DATA_W'($signed(i_vi) < $signed(i_vj));
            OP_SLTU:  o_result = DATA_W'(i_vi < i_vj);
            OP_XOR:   o_result = i_vi ^ i_vj;
            OP_SRL:   o_result = i_vi >> i_vj[4:0];
            OP_SRA:   o_result = $signed(i_vi) >>> i_vj[4:0];
            OP_OR:    o_result = i_vi | i_vj;
            OP_AND:   o_result = i_vi & i_vj;
            OP_ADDI:  o_result = i_vi + i_imm;
            OP_SLTI:  o_result = DATA_W'($signed(i_vi) < $signed(i_imm));
            OP_SLTIU: o_result = DATA_W'(i_vi < i_imm);
            OP_XORI:  o_result = i_vi ^ i_imm;
            OP_ORI:   o_result = i_vi | i_imm;
            OP_ANDI:  o_result = i_vi & i_imm;
            OP_SLLI:  o_result = i_vi << i_imm[4:0];
            OP_SRLI:  o_result = i_vi >> i_imm[4:0];
            OP_SRAI:  o_result = $signed(i_vi) >>> i_imm[4:0];
            OP_LUI:   o_result = i_imm;
            OP_AUIPC: o_result = w_pc_imm;
            OP_JAL: begin
                o_result  = w_pc4;
                o_is_jump = TRUE;
                o_taken   = TRUE;
                o_target  = w_pc_imm;
            end
            OP_JALR: begin
                o_result  = w_pc4;
                o_is_jump = TRUE;
                o_taken   = TRUE;
                o_target  = (i_vi + i_imm) & ~DATA_W'(1);
            end
            OP_BEQ:  begin w_is_branch = TRUE; w_cond = (i_vi == i_vj); end
            OP_BNE:  begin w_is_branch = TRUE; w_cond = (i_vi != i_vj); end
            OP_BLT:  begin w_is_branch = TRUE; w_cond = ($signed(i_vi) <  $signed(i_vj)); end
            OP_BGE:  begin w_is_branch = TRUE; w_cond = ($signed(i_vi) >= $signed(i_vj)); end
            OP_BLTU: begin w_is_branch = TRUE; w_cond = (i_vi <  i_vj); end
            OP_BGEU: begin w_is_branch = TRUE; w_cond = (i_vi >= i_vj); end
            default:  o_legal = FALSE;
        endcase
        // Branches write no register value, so result stays zero.
        if (w_is_branch) begin
            o_is_jump = TRUE;
            o_taken   = w_cond;
            o_target  = w_cond ? w_pc_imm : w_pc4;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU stage driving the ALU CDB port; optional ALU_STATS_EN adds saturating stats counters.
module alu_exec_unit #(
    parameter int DATA_W = alu_exec_unit_pkg::DATA_W,
    parameter int TAG_W  = alu_exec_unit_pkg::TAG_W,
    parameter int OP_W   = alu_exec_unit_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback_signal,
    input  logic [OP_W-1:0]   optype_in,
    input  logic [TAG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] vi_in,
    input  logic [DATA_W-1:0] vj_in,
    input  logic [DATA_W-1:0] imm_in,
    output logic              alu_has_result,
    output logic [TAG_W-1:0]  alias_out,
    output logic [DATA_W-1:0] result_out,
    output logic              is_jump_out,
    output logic              taken_out,
    output logic [DATA_W-1:0] target_out
`ifdef ALU_STATS_EN
   ,output logic [31:0]       exec_cnt_out,
    output logic [31:0]       br_taken_cnt_out,
    output logic [31:0]       illegal_cnt_out
`endif
);
    import alu_exec_unit_pkg::*;

    logic [DATA_W-1:0] w_result;
    logic              w_is_jump;
    logic              w_taken;
    logic [DATA_W-1:0] w_target;
    logic              w_legal;
    logic              w_valid;

    logic              r_has_result;
    logic [TAG_W-1:0]  r_alias;
    logic [DATA_W-1:0] r_result;
    logic              r_is_jump;
    logic              r_taken;
    logic [DATA_W-1:0] r_target;

    alu_compute #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_compute (
        .i_optype  (optype_in),
        .i_pc      (pc_in),
        .i_vi      (vi_in),
        .i_vj      (vj_in),
        .i_imm     (imm_in),
        .o_result  (w_result),
        .o_is_jump (w_is_jump),
        .o_taken   (w_taken),
        .o_target  (w_target),
        .o_legal   (w_legal)
    );

    // Handshake: the RS has no ready, so an op is consumed on every edge with rdy high;
    // alu_has_result is the CDB valid and no snooper can stall it.
    assign w_valid = (optype_in != OP_NOP) && w_legal;

    always_ff @(posedge clk) begin
        if (rst || rollback_signal) begin
            r_has_result <= FALSE;
            r_alias      <= TAG_W'(RENAMED_ZERO);
            r_result     <= '0;
            r_is_jump    <= FALSE;
            r_taken      <= FALSE;
            r_target     <= '0;
        end else if (rdy) begin
            if (w_valid) begin
                r_has_result <= TRUE;
                r_alias      <= rd_in;
                r_result     <= w_result;
                r_is_jump    <= w_is_jump;
                r_taken      <= w_taken;
                r_target     <= w_target;
            end else begin
                r_has_result <= FALSE;
                r_is_jump    <= FALSE;
            end
        end
    end

    assign alu_has_result = r_has_result;
    assign alias_out      = r_alias;
    assign result_out     = r_result;
    assign is_jump_out    = r_is_jump;
    assign taken_out      = r_taken;
    assign target_out     = r_target;

`ifdef ALU_STATS_EN
    logic [31:0] r_exec_cnt;
    logic [31:0] r_br_taken_cnt;
    logic [31:0] r_illegal_cnt;

    // Rollback does not clear history; it only suppresses counting of the flushed op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exec_cnt     <= '0;
            r_br_taken_cnt <= '0;
            r_illegal_cnt  <= '0;
        end else if (rdy && !rollback_signal) begin
            if (w_valid)
                r_exec_cnt <= sat_inc(r_exec_cnt);
            if (w_valid && w_taken)
                r_br_taken_cnt <= sat_inc(r_br_taken_cnt);
            if ((optype_in != OP_NOP) && !w_legal)
                r_illegal_cnt <= sat_inc(r_illegal_cnt);
        end
    end

    assign exec_cnt_out     = r_exec_cnt;
    assign br_taken_cnt_out = r_br_taken_cnt;
    assign illegal_cnt_out  = r_illegal_cnt;
`endif

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit that receives one issued instruction per cycle from the reservation station.
- Computes the RV32I result, branch outcome and jump target for that instruction.
- Broadcasts the result on the ALU common data bus (CDB) port, which the reservation station, load/store buffer and ROB all snoop.
- Registered single-cycle stage: accepts every cycle with no backpressure, because the reservation station has no ready input.

Parameters:
- DATA_W, 32, operand/result/pc width
- TAG_W, 5, ROB alias width; alias 0 = "no tag" (RENAMED_ZERO)
- OP_W, 6, optype encoding width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- rdy  in  1  global enable; low = pause, all state held
- rollback_signal  in  1  misprediction flush
- optype_in  in  OP_W  optype from RS; NOP (0) = no instruction
- rd_in  in  TAG_W  ROB alias of destination
- pc_in  in  DATA_W  instruction pc
- vi_in  in  DATA_W  rs1 value
- vj_in  in  DATA_W  rs2 value
- imm_in  in  DATA_W  sign-extended immediate
- alu_has_result  out  1  CDB valid
- alias_out  out  TAG_W  CDB tag
- result_out  out  DATA_W  CDB value (rd write value)
- is_jump_out  out  1  instruction was a branch/JAL/JALR
- taken_out  out  1  branch taken (1 for JAL/JALR)
- target_out  out  DATA_W  next pc actually required

Behaviour:
- All outputs are registers. Reset value of every output: 0.
- Latency: operands present on the inputs in cycle t produce outputs visible in cycle t+1. Throughput is 1 instruction/cycle.
- Priority: rst / rollback_signal > !rdy > normal operation.
  - rst or rollback_signal at the clock edge: all outputs cleared to 0 next cycle. The instruction presented that cycle is dropped.
  - !rdy: all outputs hold their values; inputs are ignored.
  - Normal, optype_in == NOP: alu_has_result <= 0, is_jump_out <= 0. Other outputs may hold.
  - Normal, optype_in != NOP: alu_has_result <= 1, alias_out <= rd_in. Result and flags are computed as below.
- Arithmetic, all mod 2^32. The second operand B = imm_in for I-type, vj_in for R-type.
  - ADD/ADDI: vi+B. SUB: vi-vj.
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare.
  - AND/OR/XOR: bitwise with B.
  - SLL/SRL/SRA: shift amount = B[4:0]. SRA sign-fills.
  - LUI: result = imm. AUIPC: result = pc+imm.
- JAL: result = pc+4, target = pc+imm, taken = 1.
- JALR: result = pc+4, target = (vi+imm) & ~1, taken = 1.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - result = 0.
  - taken = condition(vi, vj).
  - target = taken ? pc+imm : pc+4.
- is_jump_out = 1 only for branch/JAL/JALR; target_out/taken_out are meaningful only then.
- Non-jump instructions drive taken_out = 0 and target_out = pc+4.
- Unknown optype: treated as NOP and counted as illegal (see optional feature).
- Rollback in the same cycle as a valid input: the flush wins and the output valid is 0.
- A rollback while a valid result is already registered clears that result the next cycle.

Optional Feature:
- Macro: ALU_STATS_EN.
- When defined:
  - Three 32-bit saturating counters, cleared by rst only (not by rollback): exec_cnt (valid ops), br_taken_cnt (taken branches/jumps), illegal_cnt (unknown optypes).
  - Counters advance only when rdy=1 and no flush.
  - Exposed as extra output ports exec_cnt_out, br_taken_cnt_out, illegal_cnt_out.
- When not defined: no counters and no extra ports. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - optype encodings (NOP=0 plus all RV32I ALU/branch/jump codes);
  - DATA_W/TAG_W/OP_W and RENAMED_ZERO;
  - ZERO/TRUE/FALSE constants.
- One sub-module is natural: alu_compute, purely combinational. It takes optype/pc/vi/vj/imm and returns result/is_jump/taken/target.
- The top level holds the registers, flush/pause priority and the stats counters.

Test Plan:
- Reset then ADDI, vi=5, imm=-3, rd=7 -> next cycle has_result=1, alias=7, result=2, is_jump=0.
- SRA, vi=0x80000000, vj=0x24 -> result=0xF8000000 (shift by 4).
- SLTU, vi=1, vj=0xFFFFFFFF -> result=1. SLT with the same operands -> result=0.
- BNE, pc=0x100, vi=3, vj=4, imm=0x20 -> is_jump=1, taken=1, target=0x120, result=0. BEQ with the same operands -> taken=0, target=0x104.
- JALR, pc=0x200, vi=0x1003, imm=4 -> result=0x204, target=0x1006, taken=1.
- Timing/priority case:
  - Back-to-back ADDs on cycles 1 and 2 with rdy low on cycle 2: the output of ADD1 holds through cycle 3.
  - Assert rollback_signal alongside a valid AND -> next cycle all outputs are 0.
  - With ALU_STATS_EN: exec_cnt excludes the flushed op.
